// File: rtl/nco_1mhz_core.sv
// Sine NCO: 32-bit phase accumulator, 12-bit truncated phase, quarter-wave magnitude ROM with mirroring.
// Optional `NCO_PHASE_OFFSET_EN adds a phase_off_i port summed into the forwarded phase.
module nco_1mhz_core #(
  parameter int    ACC_W    = 32,
  parameter int    PHASE_W  = 12,
  parameter int    OUT_W    = 13,
  parameter string ROM_FILE = "nco_sin_q.hex"
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic [ACC_W-1:0] phi_inc_i,
`ifdef NCO_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0] phase_off_i,
`endif
  output logic [OUT_W-1:0] fsin_o,
  output logic             out_valid
);

  localparam int ADDR_W = PHASE_W - 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MAG_W  = OUT_W - 1;
  localparam int AMP    = (1 << MAG_W) - 1;
  localparam logic [2:0] FILL = 3'd4;

  // Quarter-wave entry k sits at phase (k+0.5) so both mirrors land on real samples.
  function automatic logic [MAG_W-1:0] sin_mag(input int k);
    real x, term, s;
    x    = 6.283185307179586 * (real'(k) + 0.5) / real'(4 * DEPTH);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return MAG_W'($rtoi(s * real'(AMP) + 0.5));
  endfunction

  // Table is computed at elaboration; ROM_FILE names the matching hex image for external flows.
  logic [MAG_W-1:0] rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [MAG_W-1:0] V = sin_mag(k);
    assign rom[k] = V;
  end
  if (ROM_FILE == "") begin : g_no_rom_image
  end

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ph_full;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               neg2_q, neg2_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               neg3_q;
  logic [OUT_W-1:0]   fsin_q, fsin_d;
  logic [OUT_W-1:0]   mag_ext;
  logic [2:0]         cnt_q, cnt_d;
  logic               vld_q;
  logic [ACC_W-1:0]   off;

`ifdef NCO_PHASE_OFFSET_EN
  assign off = phase_off_i;
`else
  assign off = '0;
`endif

  always_comb begin
    acc_d   = acc_q + phi_inc_i;
    ph_full = acc_q + off;
    phase_d = ph_full[ACC_W-1 -: PHASE_W];
    addr_d  = phase_q[ADDR_W] ? ~phase_q[ADDR_W-1:0] : phase_q[ADDR_W-1:0];
    neg2_d  = phase_q[PHASE_W-1];
    mag_d   = rom[addr_q];
    mag_ext = {1'b0, mag_q};
    // Stage-4 input is only meaningful once three enabled edges have filled the pipe.
    if (cnt_q >= 3'd3) fsin_d = neg3_q ? (~mag_ext + 1'b1) : mag_ext;
    else               fsin_d = '0;
    cnt_d   = (cnt_q == FILL) ? cnt_q : cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      phase_q <= '0;
      addr_q  <= '0;
      neg2_q  <= 1'b0;
      mag_q   <= '0;
      neg3_q  <= 1'b0;
      fsin_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else if (clken) begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      neg2_q  <= neg2_d;
      mag_q   <= mag_d;
      neg3_q  <= neg2_q;
      fsin_q  <= fsin_d;
      cnt_q   <= cnt_d;
      vld_q   <= (cnt_d == FILL);
    end
  end

  assign fsin_o    = fsin_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_nco_1mhz_core.sv
// Scoreboarded bench for nco_1mhz_core: full-circle sine reference model, randomized segments.
module tb_nco_1mhz_core;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b1;
  logic [31:0] phi_inc_i = 32'h0083126F;
  logic [31:0] phase_off_i = '0;
  logic [12:0] fsin_o;
  logic        out_valid;

  always #5 clk = ~clk;

  nco_1mhz_core dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .phi_inc_i(phi_inc_i),
`ifdef NCO_PHASE_OFFSET_EN
    .phase_off_i(phase_off_i),
`endif
    .fsin_o(fsin_o), .out_valid(out_valid)
  );

  int n_vec = 0;
  int n_err = 0;
  int sb[$];
  logic [31:0] macc = '0;
  int seen_max = 0;
  int seen_min = 0;

  function automatic int ref_sin(input logic [31:0] ph);
    real x, r;
    x = 6.283185307179586 * (real'(ph[31:20]) + 0.5) / 4096.0;
    r = 4095.0 * $sin(x);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected sample for an enabled edge is queued here.
  task automatic step(input logic r, input logic ce, input logic [31:0] inc, input logic [31:0] off);
    logic [31:0] eff;
    @(negedge clk);
    reset_n = r; clken = ce; phi_inc_i = inc; phase_off_i = off;
`ifdef NCO_PHASE_OFFSET_EN
    eff = off;
`else
    eff = '0;
`endif
    if (!r) begin
      sb.delete();
      macc = '0;
    end else if (ce) begin
      sb.push_back(ref_sin(macc + eff));
      macc = macc + inc;
    end
  endtask

  task automatic run(input int n, input logic [31:0] inc);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, inc, 32'h0);
  endtask

  // Monitor: classifies each edge and checks hold, reset, fill and sample values.
  initial begin : monitor
    logic r_s, c_s;
    int fill, prev_f, prev_v, exp;
    fill = 0; prev_f = 0; prev_v = 0;
    forever begin
      @(posedge clk);
      r_s = reset_n; c_s = clken;
      #1;
      if (!r_s) begin
        fill = 0;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_fsin", int'($signed(fsin_o)), 0);
      end else if (!c_s) begin
        chk("hold_fsin", int'($signed(fsin_o)), prev_f);
        chk("hold_valid", int'(out_valid), prev_v);
      end else begin
        if (fill < 4) fill++;
        chk("valid", int'(out_valid), (fill == 4) ? 1 : 0);
        if (fill == 4) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            exp = sb.pop_front();
            chk("sample", int'($signed(fsin_o)), exp);
            if (int'($signed(fsin_o)) > seen_max) seen_max = int'($signed(fsin_o));
            if (int'($signed(fsin_o)) < seen_min) seen_min = int'($signed(fsin_o));
          end
        end else begin
          chk("fill_fsin", int'($signed(fsin_o)), 0);
        end
      end
      prev_f = int'($signed(fsin_o));
      prev_v = int'(out_valid);
    end
  end

  initial begin : driver
    logic [31:0] inc, off;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'h0083126F, 32'h0);
    run(12, 32'h0);
    step(1'b0, 1'b1, 32'h40000000, 32'h0);
    run(20, 32'h40000000);
    step(1'b0, 1'b1, 32'h0083126F, 32'h0);
    seen_max = 0; seen_min = 0;
    run(300, 32'h0083126F);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0083126F, 32'h0);
    run(800, 32'h0083126F);
    chk("tone_peak_pos", seen_max, 4095);
    chk("tone_peak_neg", seen_min, -4095);
    step(1'b0, 1'b1, 32'h0083126F, 32'h0);
    run(20, 32'h0083126F);
    for (int s = 0; s < 8; s++) begin
      case ($urandom_range(0, 3))
        0:       inc = 32'h0;
        1:       inc = 32'h80000000 | $urandom();
        default: inc = $urandom_range(0, 32'h0400_0000);
      endcase
      off = $urandom();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 199) == 0) step(1'b0, 1'b1, inc, off);
        else step(1'b1, ($urandom_range(0, 99) < 85), inc, off);
        if ($urandom_range(0, 9) == 0) off = $urandom();
      end
    end
    run(6, 32'h0083126F);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
